// File: rtl/pipeline_pkg.sv
// Shared front-end pipeline definitions: NOP encoding, reset-PC default,
// 2-bit branch counter encodings and the BTB update payload.
package pipeline_pkg;

  localparam int unsigned XLEN             = 32;
  localparam logic [31:0] NOP              = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // 2-bit saturating direction counter; bit 1 is the taken prediction.
  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  // Resolved control-flow update; pc is a word address (byte bits dropped).
  typedef struct packed {
    logic        valid;
    logic        taken;
    logic [29:0] pc_w;
    logic [31:0] target;
  } btb_upd_t;

  // Saturating step of the direction counter toward the observed outcome.
  function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
    ctr_e n;
    n = c;
    if (taken) begin
      if (c != CTR_ST) n = ctr_e'(2'(c) + 2'd1);
    end else begin
      if (c != CTR_SNT) n = ctr_e'(2'(c) - 2'd1);
    end
    return n;
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus bundle.
//   master: pipeline/memory side (drives control, update, imem_rdata)
//   slave : fetch unit (drives imem_addr and the IF/ID payload)
interface if_fetch_unit_if;
  logic        en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        predictedTaken_out;
  logic [31:0] predictedTarget_out;

  modport master (
    output en, redirect, redirect_pc, upd_valid, upd_pc, upd_taken, upd_target,
    output imem_rdata,
    input  imem_addr, pc_out, instr_out, predictedTaken_out, predictedTarget_out
  );

  modport slave (
    input  en, redirect, redirect_pc, upd_valid, upd_pc, upd_taken, upd_target,
    input  imem_rdata,
    output imem_addr, pc_out, instr_out, predictedTaken_out, predictedTarget_out
  );
endinterface

// File: rtl/btb_dm.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Ports: clk, rst_n; lookup_pc_i (word address) -> pred_taken_c_o,
// pred_target_c_o (combinational); upd_i (resolved branch update).
module btb_dm
  import pipeline_pkg::*;
#(
  parameter int unsigned BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [29:0] lookup_pc_i,
  output logic        pred_taken_c_o,
  output logic [31:0] pred_target_c_o,
  input  btb_upd_t    upd_i
);

  localparam int unsigned IDX   = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = 30 - IDX;

  logic [BTB_ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
  logic [31:0]            target_q [BTB_ENTRIES];
  ctr_e                   ctr_q    [BTB_ENTRIES];

  logic [IDX-1:0]   lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit;

  assign lk_idx = lookup_pc_i[IDX-1:0];
  assign lk_tag = lookup_pc_i[29:IDX];
  assign up_idx = upd_i.pc_w[IDX-1:0];
  assign up_tag = upd_i.pc_w[29:IDX];

  // Lookup reads the registered contents, so a same-cycle update is not seen.
  assign lk_hit          = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken_c_o  = lk_hit && ctr_q[lk_idx][1];
  assign pred_target_c_o = pred_taken_c_o ? target_q[lk_idx] : 32'h0;

  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // Valid bits are the only reset state; payload is masked while invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (upd_i.valid && !up_hit && upd_i.taken) begin
      valid_q[up_idx] <= 1'b1;
    end
  end

  // Payload: train on hit, allocate weak-taken on a taken miss.
  always_ff @(posedge clk) begin
    if (upd_i.valid) begin
      if (up_hit) begin
        ctr_q[up_idx] <= ctr_next(ctr_q[up_idx], upd_i.taken);
        if (upd_i.taken) target_q[up_idx] <= upd_i.target;
      end else if (upd_i.taken) begin
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= upd_i.target;
        ctr_q[up_idx]    <= CTR_WT;
      end
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: PC register, next-PC selection and BTB prediction.
// Ports: clk, rst_n (async, active-low), bus (if_fetch_unit_if.slave) carrying
// stall/redirect control, BTB update, imem address/data and IF/ID outputs.
module if_fetch_unit
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int unsigned BTB_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  if_fetch_unit_if.slave  bus
);

  logic [31:0] pc_q, pc_d;
  logic        pred_taken;
  logic [31:0] pred_target;
  btb_upd_t    upd;

  assign upd = '{valid:  bus.upd_valid,
                 taken:  bus.upd_taken,
                 pc_w:   bus.upd_pc[31:2],
                 target: bus.upd_target};

  btb_dm #(.BTB_ENTRIES(BTB_ENTRIES)) u_btb (
    .clk             (clk),
    .rst_n           (rst_n),
    .lookup_pc_i     (pc_q[31:2]),
    .pred_taken_c_o  (pred_taken),
    .pred_target_c_o (pred_target),
    .upd_i           (upd)
  );

  // Next PC: redirect beats stall, stall beats prediction.
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (bus.redirect)     pc_d = {bus.redirect_pc[31:2], 2'b00};
    else if (!bus.en)     pc_d = pc_q;
    else if (pred_taken)  pc_d = {pred_target[31:2], 2'b00};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign bus.imem_addr           = pc_q;
  assign bus.pc_out              = pc_q;
  assign bus.instr_out           = bus.imem_rdata;
  assign bus.predictedTaken_out  = pred_taken;
  assign bus.predictedTarget_out = pred_target;

  // Byte-offset bits are forced to word alignment and never consumed.
  logic unused_c;
  assign unused_c = ^{bus.upd_pc[1:0], bus.redirect_pc[1:0], pred_target[1:0]};

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC loaded at reset.
REQ-002 Parameter BTB_ENTRIES, default 16, BTB depth; power of two, 4..64.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 en  in  1  1 = advance PC; 0 = stall, hold PC.
REQ-006 redirect  in  1  mispredict/control correction from EX.
REQ-007 redirect_pc  in  32  corrected fetch address.
REQ-008 upd_valid  in  1  resolved control-flow instruction, BTB update strobe.
REQ-009 upd_pc  in  32  PC of resolved instruction.
REQ-010 upd_taken  in  1  actual direction.
REQ-011 upd_target  in  32  actual target.
REQ-012 imem_addr  out  32  instruction memory address.
REQ-013 imem_rdata  in  32  instruction word; combinational from imem_addr.
REQ-014 pc_out  out  32  current fetch PC, to IF/ID pc_in.
REQ-015 instr_out  out  32  fetched instruction, to IF/ID instr_in.
REQ-016 predictedTaken_out  out  1  BTB prediction, to IF/ID.
REQ-017 predictedTarget_out  out  32  predicted target, to IF/ID; 0 when not taken.

Function
REQ-018 State: pc_q (32b); BTB entry = valid, tag = pc[31:2+IDX], target[31:0], ctr[1:0]; IDX = log2(BTB_ENTRIES), index = pc[IDX+1:2].
REQ-019 imem_addr = pc_out = pc_q; instr_out = imem_rdata; zero added latency.
REQ-020 Lookup combinational on pc_q: hit = valid && tag match; predictedTaken_out = hit && ctr[1]; predictedTarget_out = target when taken, else 0.
REQ-021 Next-PC priority, highest first: redirect -> {redirect_pc[31:2],2'b00}; !en -> hold pc_q; predictedTaken_out -> {predictedTarget_out[31:2],2'b00}; else pc_q+4.
REQ-022 redirect overrides en=0 in the same cycle.
REQ-023 pc_q+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-024 BTB update on upd_valid edge, independent of en and redirect; uses upd_pc index/tag.
REQ-025 Update, tag hit: ctr saturating +1 if upd_taken, -1 otherwise (3 max, 0 min); target <= upd_target when taken.
REQ-026 Update, miss and taken: allocate/replace: valid=1, tag, target=upd_target, ctr=2'b10.
REQ-027 Update, miss and not taken: no change.
REQ-028 Lookup and update on the same entry in one cycle: lookup sees pre-update contents.
REQ-029 Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.

Reset
REQ-030 rst_n low: pc_q = RESET_PC, all BTB valid bits = 0, immediately (asynchronous).
REQ-031 During/after reset until first update: predictedTaken_out=0, predictedTarget_out=0, pc_out=RESET_PC.
REQ-032 BTB target/tag/ctr need no reset; must be unobservable while valid=0.
REQ-033 Reset mid-stall or mid-redirect: reset wins; pending redirect discarded.

Structure
REQ-034 Shared package pipeline_pkg holds NOP (32'h0000_0013), counter encodings, reset-PC default.
REQ-035 BTB storage, lookup, update in sub-module btb_dm; if_fetch_unit holds pc_q and next-PC mux only.

Verification
REQ-036 Reset release, en=1, empty BTB -> pc_out 0,4,8,12 on successive cycles; predictedTaken_out=0.
REQ-037 en=0 for 3 cycles at pc 8 -> pc_out stays 8; en=1 -> 12.
REQ-038 en=0 and redirect=1, redirect_pc=32'h100 -> next pc_out 32'h100; redirect_pc 32'h103 -> 32'h100.
REQ-039 upd_valid, upd_pc=32'h10, taken, target 32'h80; then fetch 32'h10 -> predictedTaken_out=1, target 32'h80, next pc_out 32'h80.
REQ-040 Same entry: two not-taken updates -> ctr 00, predictedTaken_out=0; one taken -> 01, still 0; second taken -> 10, predicts taken.
REQ-041 Alias: entry for 32'h10 valid; fetch 32'h50 (same index, tag differs at depth 16) -> no prediction, pc_out next 32'h54; pc 32'hFFFF_FFFC sequential -> 32'h0.
